// File: rtl/axi_lite_scratchpad_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_scratchpad_responder
//
// AXI4-Lite subordinate fronting a word-addressed scratchpad SRAM. Write
// address and write data are accepted independently (either order, or
// together), byte strobes are applied on commit, and B/R responses carry
// OKAY for in-range accesses or SLVERR for addresses outside the window
// [BASE_ADDR, BASE_ADDR+SIZE_BYTES). Allows one read and one write in flight.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   io_s_axi_aw_*                write address channel (valid/ready/addr)
//   io_s_axi_w_*                 write data channel (valid/ready/data/strb)
//   io_s_axi_b_*                 write response channel (valid/ready/resp)
//   io_s_axi_ar_*                read address channel (valid/ready/addr)
//   io_s_axi_r_*                 read data channel (valid/ready/data/resp)
//
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
// ---------------------------------------------------------------------------
module axi_lite_scratchpad_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0800_0000,
  parameter int                    SIZE_BYTES = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_s_axi_aw_valid,
  output logic                    io_s_axi_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_aw_bits_addr,
  input  logic                    io_s_axi_w_valid,
  output logic                    io_s_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_s_axi_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] io_s_axi_w_bits_strb,
  output logic                    io_s_axi_b_valid,
  input  logic                    io_s_axi_b_ready,
  output logic [1:0]              io_s_axi_b_bits_resp,
  input  logic                    io_s_axi_ar_valid,
  output logic                    io_s_axi_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_ar_bits_addr,
  output logic                    io_s_axi_r_valid,
  input  logic                    io_s_axi_r_ready,
  output logic [DATA_WIDTH-1:0]   io_s_axi_r_bits_data,
  output logic [1:0]              io_s_axi_r_bits_resp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int DEPTH  = SIZE_BYTES / STRB_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(SIZE_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_RESP
  } r_state_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SIZE_A);
  endfunction

  // Alignment bits below LSB are dropped; out-of-range addresses never use it.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  // -------------------------------------------------------------------------
  // State and holding registers
  // -------------------------------------------------------------------------
  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_ready_q, w_ready_q, ar_ready_q;
  logic                  b_valid_q, r_valid_q;
  logic [1:0]            b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic aw_hs, w_hs, ar_hs;
  logic wr_hit, rd_hit;

  assign aw_hs  = io_s_axi_aw_valid && aw_ready_q;
  assign w_hs   = io_s_axi_w_valid  && w_ready_q;
  assign ar_hs  = io_s_axi_ar_valid && ar_ready_q;
  assign wr_hit = in_range(aw_addr_q);
  assign rd_hit = in_range(io_s_axi_ar_bits_addr);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_COMMIT;
        else if (aw_hs)    w_state_d = W_HAVE_AW;
        else if (w_hs)     w_state_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  w_state_d = W_COMMIT;
      W_HAVE_W:  if (aw_hs) w_state_d = W_COMMIT;
      W_COMMIT:  w_state_d = W_RESP;
      W_RESP:    if (io_s_axi_b_ready) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase

    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (io_s_axi_r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. Readys are registered from the next state so they sit at 0
  // throughout reset and rise on the first clock after it is released.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_ready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
      w_ready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
      ar_ready_q <= (r_state_d == R_IDLE);
      b_valid_q  <= (w_state_d == W_RESP);
      r_valid_q  <= (r_state_d == R_RESP);

      if (aw_hs) aw_addr_q <= io_s_axi_aw_bits_addr;
      if (w_hs) begin
        w_data_q <= io_s_axi_w_bits_data;
        w_strb_q <= io_s_axi_w_bits_strb;
      end
      if (w_state_q == W_COMMIT) b_resp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;

      // Reads sample mem before this edge's write lands: read-first.
      if (ar_hs) begin
        r_data_q <= rd_hit ? mem[word_idx(io_s_axi_ar_bits_addr)] : '0;
        r_resp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // NOTE: the SRAM array has no reset; clearing it would turn a single RAM
  // macro into thousands of resettable flops.
  always_ff @(posedge clock) begin
    if (w_state_q == W_COMMIT && wr_hit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign io_s_axi_aw_ready    = aw_ready_q;
  assign io_s_axi_w_ready     = w_ready_q;
  assign io_s_axi_ar_ready    = ar_ready_q;
  assign io_s_axi_b_valid     = b_valid_q;
  assign io_s_axi_b_bits_resp = b_resp_q;
  assign io_s_axi_r_valid     = r_valid_q;
  assign io_s_axi_r_bits_data = r_data_q;
  assign io_s_axi_r_bits_resp = r_resp_q;

endmodule

// File: tb/tb_axi_lite_scratchpad_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_scratchpad_responder
//
// Directed bench for axi_lite_scratchpad_responder with default parameters
// (32-bit data, 4 KiB window at 0x0800_0000). Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_scratchpad_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        b_valid, b_ready = 1'b1;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic        r_valid, r_ready = 1'b1;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  always #5 clock = ~clock;

  axi_lite_scratchpad_responder dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_s_axi_aw_valid     (aw_valid),
    .io_s_axi_aw_ready     (aw_ready),
    .io_s_axi_aw_bits_addr (aw_addr),
    .io_s_axi_w_valid      (w_valid),
    .io_s_axi_w_ready      (w_ready),
    .io_s_axi_w_bits_data  (w_data),
    .io_s_axi_w_bits_strb  (w_strb),
    .io_s_axi_b_valid      (b_valid),
    .io_s_axi_b_ready      (b_ready),
    .io_s_axi_b_bits_resp  (b_resp),
    .io_s_axi_ar_valid     (ar_valid),
    .io_s_axi_ar_ready     (ar_ready),
    .io_s_axi_ar_bits_addr (ar_addr),
    .io_s_axi_r_valid      (r_valid),
    .io_s_axi_r_ready      (r_ready),
    .io_s_axi_r_bits_data  (r_data),
    .io_s_axi_r_bits_resp  (r_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full AW+W write with b_ready high; call on a falling edge.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int n = 0;
    while (!(aw_ready && w_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_wrdy"}, {aw_ready, w_ready}, 2'b11);
    aw_valid = 1'b1; aw_addr = addr;
    w_valid  = 1'b1; w_data  = data; w_strb = strb;
    @(negedge clock);
    aw_valid = 1'b0; w_valid = 1'b0;
    check({tag, "_bv_commit"}, b_valid, 1'b0);
    @(negedge clock);
    check({tag, "_bv"}, b_valid, 1'b1);
    check({tag, "_bresp"}, b_resp, exp_resp);
    @(negedge clock);
    check({tag, "_bv_done"}, {b_valid, aw_ready, w_ready}, 3'b011);
  endtask

  // Single read with r_ready high; call on a falling edge.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    while (!ar_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_arrdy"}, ar_ready, 1'b1);
    ar_valid = 1'b1; ar_addr = addr;
    @(negedge clock);
    ar_valid = 1'b0;
    check({tag, "_rv"}, r_valid, 1'b1);
    check({tag, "_rdata"}, r_data, exp_data);
    check({tag, "_rresp"}, r_resp, exp_resp);
    @(negedge clock);
    check({tag, "_rv_done"}, {r_valid, ar_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held for 10 cycles, everything quiet.
    repeat (10) begin
      @(negedge clock);
      check("rst_quiet", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b0);
    end
    check("rst_rdata", {r_data, r_resp, b_resp}, '0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_rdy", {aw_ready, w_ready, ar_ready}, 3'b111);

    // 2: AW+W together, then read back.
    do_write("t2_wr", 32'h0800_0004, 32'hDEAD_BEEF, 4'hF, OKAY);
    do_read ("t2_rd", 32'h0800_0004, 32'hDEAD_BEEF, OKAY);

    // 3: W first with partial strobe, AW three cycles later.
    w_valid = 1'b1; w_data = 32'h1122_3344; w_strb = 4'h5;
    @(negedge clock);
    w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_aw_rdy_held", {aw_ready, w_ready, b_valid}, 3'b100);
      if (i < 2) @(negedge clock);
    end
    aw_valid = 1'b1; aw_addr = 32'h0800_0004;
    @(negedge clock);
    aw_valid = 1'b0;
    check("t3_bv_commit", b_valid, 1'b0);
    @(negedge clock);
    check("t3_bv", {b_valid, b_resp}, {1'b1, OKAY});
    @(negedge clock);
    do_read("t3_rd", 32'h0800_0004, 32'hDE22_BE44, OKAY);

    // 4: out-of-range accesses and window boundaries.
    do_write("t4_w0",    32'h0800_0000, 32'h0BAD_F00D, 4'hF, OKAY);
    do_write("t4_oor",   32'h2000_0000, 32'hFFFF_FFFF, 4'hF, SLVERR);
    do_read ("t4_oor",   32'h0800_1000, 32'h0,         SLVERR);
    do_read ("t4_below", 32'h07FF_FFFC, 32'h0,         SLVERR);
    do_read ("t4_w0",    32'h0800_0000, 32'h0BAD_F00D, OKAY);
    do_write("t4_last",  32'h0800_0FFF, 32'h1357_9BDF, 4'hF, OKAY);
    do_read ("t4_last",  32'h0800_0FFC, 32'h1357_9BDF, OKAY);
    do_write("t4_strb0", 32'h0800_0000, 32'hFFFF_FFFF, 4'h0, OKAY);
    do_read ("t4_strb0", 32'h0800_0000, 32'h0BAD_F00D, OKAY);

    // 5: back-pressure on B and R together.
    b_ready = 1'b0; r_ready = 1'b0;
    aw_valid = 1'b1; aw_addr = 32'h0800_0008;
    w_valid  = 1'b1; w_data  = 32'hCAFE_F00D; w_strb = 4'hF;
    ar_valid = 1'b1; ar_addr = 32'h0800_0004;
    @(negedge clock);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    check("t5_rv_early", {r_valid, b_valid}, 2'b10);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_v", {b_valid, r_valid, aw_ready, w_ready, ar_ready}, 5'b11000);
      check("t5_hold_d", {r_data, r_resp, b_resp}, {32'hDE22_BE44, OKAY, OKAY});
      @(negedge clock);
    end
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clock);
    check("t5_release", {b_valid, r_valid, aw_ready, w_ready, ar_ready}, 5'b00111);
    do_read("t5_rd", 32'h0800_0008, 32'hCAFE_F00D, OKAY);

    // 6: reset while the write holds only AW and a read response is pending.
    r_ready = 1'b0;
    aw_valid = 1'b1; aw_addr = 32'h0800_000C;
    ar_valid = 1'b1; ar_addr = 32'h0800_0008;
    @(negedge clock);
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("t6_pre", {r_valid, aw_ready, w_ready, ar_ready}, 4'b1010);
    #2 reset = 1'b1;
    #1;
    check("t6_async_clr", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b0);
    check("t6_async_data", {r_data, r_resp, b_resp}, '0);
    @(negedge clock);
    reset = 1'b0; r_ready = 1'b1;
    @(negedge clock);
    check("t6_rdy_back", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 5'b11100);
    do_write("t6_wr", 32'h0800_000C, 32'h5A5A_1234, 4'hF, OKAY);
    do_read ("t6_rd", 32'h0800_000C, 32'h5A5A_1234, OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
